// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter FIFO.
interface uart_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: bytes enter a small FIFO on a valid/ready handshake and leave on txd_o
// as start + 8 data bits (LSB first) + optional parity + 1 or 2 stop bits.
module uart_tx #(
   parameter int unsigned CLK_DIV    = 10417,
   parameter bit          PARITY_EN  = 1'b0,
   parameter bit          PARITY_ODD = 1'b0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   uart_tx_if.slave                    tx_if,
   output logic                        txd_o,
   output logic                        busy_o,
   output logic [$clog2(FIFO_DEPTH):0] fifo_cnt_o
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned BW = $clog2(CLK_DIV);
   localparam logic [BW-1:0] BaudLast = BW'(CLK_DIV - 1);
   localparam logic [2:0]    StopLast = 3'(STOP_BITS - 1);
   localparam logic [AW:0]   FifoFull = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    data_q, data_d;
   logic          txd_q, txd_d;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr_q, wr_ptr_q;
   logic [AW:0]   cnt_q;
   logic          ready, push, pop;
   logic          baud_end, par_bit;

   assign ready          = !rst && (cnt_q < FifoFull);
   assign push           = tx_if.tx_valid && ready;
   assign tx_if.tx_ready = ready;
   assign baud_end       = (baud_q == BaudLast);
   assign par_bit        = PARITY_ODD ? ~^data_q : ^data_q;

   assign txd_o      = txd_q;
   assign busy_o     = (state_q != StIdle) || (cnt_q != '0);
   assign fifo_cnt_o = cnt_q;

   // FIFO pointers and occupancy; a push and pop on the same edge cancel out in the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (push && !pop)      cnt_q <= cnt_q + (AW + 1)'(1);
         else if (!push && pop) cnt_q <= cnt_q - (AW + 1)'(1);
      end
   end

   // FIFO storage; contents need no reset because the count gates every read.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= tx_if.tx_data;
   end

   // Frame state register; reset drops the line high and abandons any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         baud_q  <= '0;
         bit_q   <= '0;
         data_q  <= '0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         data_q  <= data_d;
         txd_q   <= txd_d;
      end
   end

   // Next-state and next line level; every bit boundary restarts the baud counter at zero.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      data_d  = data_q;
      txd_d   = txd_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            txd_d = 1'b1;
            if (cnt_q != '0) begin
               pop     = 1'b1;
               data_d  = mem_q[rd_ptr_q];
               txd_d   = 1'b0;
               baud_d  = '0;
               bit_d   = '0;
               state_d = StStart;
            end
         end
         StStart: begin
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = '0;
               txd_d   = data_q[0];
               state_d = StData;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         StData: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  bit_d = '0;
                  if (PARITY_EN) begin
                     txd_d   = par_bit;
                     state_d = StParity;
                  end else begin
                     txd_d   = 1'b1;
                     state_d = StStop;
                  end
               end else begin
                  bit_d = bit_q + 3'd1;
                  txd_d = data_q[bit_d];
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         StParity: begin
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = '0;
               txd_d   = 1'b1;
               state_d = StStop;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         StStop: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == StopLast) begin
                  bit_d = '0;
                  // Chain straight into the next frame when a byte is waiting.
                  if (cnt_q != '0) begin
                     pop     = 1'b1;
                     data_d  = mem_q[rd_ptr_q];
                     txd_d   = 1'b0;
                     state_d = StStart;
                  end else begin
                     state_d = StIdle;
                  end
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         default: begin
            state_d = StIdle;
            txd_d   = 1'b1;
         end
      endcase
   end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three differently configured instances checked cycle by cycle against
// a frame-position model (which bit of which byte is on the line, from elapsed cycles).
module tb_uart_tx;
   localparam int NI = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       vld [NI];
   logic [7:0] dat [NI];
   logic       txd_w [NI];
   logic       busy_w [NI];
   logic       rdy_w [NI];
   logic [2:0] cnt_w [NI];
   logic [2:0] cnt0, cnt1;
   logic [1:0] cnt2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_tx_if if0 ();
   uart_tx_if if1 ();
   uart_tx_if if2 ();

   assign if0.tx_valid = vld[0];
   assign if0.tx_data  = dat[0];
   assign if1.tx_valid = vld[1];
   assign if1.tx_data  = dat[1];
   assign if2.tx_valid = vld[2];
   assign if2.tx_data  = dat[2];
   assign rdy_w[0] = if0.tx_ready;
   assign rdy_w[1] = if1.tx_ready;
   assign rdy_w[2] = if2.tx_ready;
   assign cnt_w[0] = cnt0;
   assign cnt_w[1] = cnt1;
   assign cnt_w[2] = {1'b0, cnt2};

   uart_tx #(.CLK_DIV(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1), .FIFO_DEPTH(4))
      dut0 (.clk(clk), .rst(rst), .tx_if(if0), .txd_o(txd_w[0]), .busy_o(busy_w[0]),
            .fifo_cnt_o(cnt0));
   uart_tx #(.CLK_DIV(3), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2), .FIFO_DEPTH(4))
      dut1 (.clk(clk), .rst(rst), .tx_if(if1), .txd_o(txd_w[1]), .busy_o(busy_w[1]),
            .fifo_cnt_o(cnt1));
   uart_tx #(.CLK_DIV(5), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1), .FIFO_DEPTH(2))
      dut2 (.clk(clk), .rst(rst), .tx_if(if2), .txd_o(txd_w[2]), .busy_o(busy_w[2]),
            .fifo_cnt_o(cnt2));

   // Per-instance configuration as seen by the model.
   function automatic int cdiv(int k);
      return (k == 0) ? 4 : (k == 1) ? 3 : 5;
   endfunction
   function automatic bit pen(int k);
      return k != 0;
   endfunction
   function automatic bit podd(int k);
      return k == 2;
   endfunction
   function automatic int stopb(int k);
      return (k == 1) ? 2 : 1;
   endfunction
   function automatic int depth(int k);
      return (k == 2) ? 2 : 4;
   endfunction
   function automatic int flen(int k);
      return cdiv(k) * (10 + int'(pen(k)) + stopb(k) - 1);
   endfunction

   // Model: byte queue plus position (in clk cycles) within the current frame, -1 when idle.
   logic [7:0] mq [NI][8];
   int         mhead [NI];
   int         mcnt [NI];
   int         mpos [NI];
   logic [7:0] mcur [NI];
   bit         macc [NI];

   function automatic void model_step();
      for (int k = 0; k < NI; k++) begin
         bit acc;
         acc = vld[k] && !rst && (mcnt[k] < depth(k));
         macc[k] = acc;
         if (rst) begin
            mhead[k] = 0;
            mcnt[k]  = 0;
            mpos[k]  = -1;
         end else begin
            if (mpos[k] >= 0) begin
               mpos[k]++;
               if (mpos[k] == flen(k)) mpos[k] = -1;
            end
            if (mpos[k] < 0 && mcnt[k] > 0) begin
               mcur[k]  = mq[k][mhead[k]];
               mhead[k] = (mhead[k] + 1) % depth(k);
               mcnt[k]--;
               mpos[k]  = 0;
            end
            if (acc) begin
               mq[k][(mhead[k] + mcnt[k]) % depth(k)] = dat[k];
               mcnt[k]++;
            end
         end
      end
   endfunction

   function automatic logic exp_txd(int k);
      int i;
      if (mpos[k] < 0) return 1'b1;
      i = mpos[k] / cdiv(k);
      if (i == 0) return 1'b0;
      if (i <= 8) return mcur[k][i-1];
      if (pen(k) && i == 9) return podd(k) ? ~^mcur[k] : ^mcur[k];
      return 1'b1;
   endfunction

   function automatic logic exp_busy(int k);
      return (mpos[k] >= 0) || (mcnt[k] > 0);
   endfunction

   function automatic logic exp_ready(int k);
      return !rst && (mcnt[k] < depth(k));
   endfunction

   function automatic bit all_idle();
      for (int k = 0; k < NI; k++) if (exp_busy(k)) return 1'b0;
      return 1'b1;
   endfunction

   // One clock: model advances on the edge, outputs are compared at the following negedge.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic push_byte(input int k, input logic [7:0] b);
      bit done;
      done   = 1'b0;
      vld[k] = 1'b1;
      dat[k] = b;
      for (int n = 0; n < 500 && !done; n++) begin
         tick();
         done = macc[k];
      end
      vld[k] = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL push_accept k=%0d got not-accepted required accepted", k);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      for (int k = 0; k < NI; k++) begin
         checks += 4;
         if (txd_w[k] !== 1'b1) begin
            errors++; $display("FAIL reset_txd k=%0d got %b required 1", k, txd_w[k]);
         end
         if (busy_w[k] !== 1'b0) begin
            errors++; $display("FAIL reset_busy k=%0d got %b required 0", k, busy_w[k]);
         end
         if (rdy_w[k] !== 1'b0) begin
            errors++; $display("FAIL reset_ready k=%0d got %b required 0", k, rdy_w[k]);
         end
         if (cnt_w[k] !== 3'd0) begin
            errors++; $display("FAIL reset_cnt k=%0d got %0d required 0", k, cnt_w[k]);
         end
      end
      rst = 1'b0;
      tick();
      for (int k = 0; k < NI; k++) begin
         checks++;
         if (rdy_w[k] !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready k=%0d got %b required 1", k, rdy_w[k]);
         end
      end
   endtask

   // Single frames per instance: directed 0x55 / 0x07 first, then random bytes.
   task automatic test_single_frame();
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < NI; k++) begin
            logic [7:0] b;
            b = (r == 0) ? ((k == 0) ? 8'h55 : 8'h07) : 8'($urandom);
            push_byte(k, b);
         end
         for (int n = 0; n < 300 && !all_idle(); n++) begin
            tick();
            for (int k = 0; k < NI; k++) begin
               checks += 2;
               if (txd_w[k] !== exp_txd(k)) begin
                  errors++;
                  $display("FAIL frame_txd k=%0d pos=%0d got %b required %b", k, mpos[k],
                           txd_w[k], exp_txd(k));
               end
               if (busy_w[k] !== exp_busy(k)) begin
                  errors++;
                  $display("FAIL frame_busy k=%0d pos=%0d got %b required %b", k, mpos[k],
                           busy_w[k], exp_busy(k));
               end
            end
         end
         checks++;
         if (!all_idle()) begin
            errors++; $display("FAIL frame_drain got busy required idle");
         end
         tick();
      end
   endtask

   // Six bytes per instance with valid held high: FIFO fills, ready drops, frames chain.
   task automatic test_back_to_back();
      logic [7:0] list [NI][6];
      int         sent [NI];
      for (int i = 0; i < 6; i++) begin
         list[0][i] = 8'(i + 1);
         list[1][i] = (i == 0) ? 8'hFF : (i == 1) ? 8'h00 : 8'($urandom);
         list[2][i] = 8'($urandom);
      end
      for (int k = 0; k < NI; k++) begin
         sent[k] = 0;
         vld[k]  = 1'b1;
         dat[k]  = list[k][0];
      end
      for (int n = 0; n < 1500 && !(all_idle() && sent[0] == 6 && sent[1] == 6 &&
                                    sent[2] == 6); n++) begin
         tick();
         for (int k = 0; k < NI; k++) begin
            if (macc[k]) begin
               sent[k]++;
               vld[k] = (sent[k] < 6);
               if (sent[k] < 6) dat[k] = list[k][sent[k]];
            end
            checks += 4;
            if (txd_w[k] !== exp_txd(k)) begin
               errors++;
               $display("FAIL b2b_txd k=%0d pos=%0d got %b required %b", k, mpos[k],
                        txd_w[k], exp_txd(k));
            end
            if (busy_w[k] !== exp_busy(k)) begin
               errors++; $display("FAIL b2b_busy k=%0d got %b required %b", k, busy_w[k],
                                  exp_busy(k));
            end
            if (rdy_w[k] !== exp_ready(k)) begin
               errors++; $display("FAIL b2b_ready k=%0d got %b required %b", k, rdy_w[k],
                                  exp_ready(k));
            end
            if (cnt_w[k] !== 3'(mcnt[k])) begin
               errors++; $display("FAIL b2b_cnt k=%0d got %0d required %0d", k, cnt_w[k],
                                  mcnt[k]);
            end
         end
      end
      for (int k = 0; k < NI; k++) begin
         vld[k] = 1'b0;
         checks++;
         if (sent[k] != 6) begin
            errors++; $display("FAIL b2b_sent k=%0d got %0d required 6", k, sent[k]);
         end
      end
   endtask

   // Reset pulse during data bit 3 of instance 0 with two more bytes queued.
   task automatic test_reset_mid_frame();
      bit hit;
      push_byte(0, 8'($urandom));
      push_byte(0, 8'($urandom));
      push_byte(0, 8'($urandom));
      hit = 1'b0;
      for (int n = 0; n < 300 && !hit; n++) begin
         tick();
         hit = (mpos[0] == 4 * cdiv(0) + 1);
      end
      checks += 2;
      if (!hit) begin
         errors++; $display("FAIL midrst_reach got timeout required data bit 3");
      end
      if (txd_w[0] !== exp_txd(0)) begin
         errors++; $display("FAIL midrst_bit3 got %b required %b", txd_w[0], exp_txd(0));
      end
      rst = 1'b1;
      tick();
      checks += 4;
      if (txd_w[0] !== 1'b1) begin
         errors++; $display("FAIL midrst_txd got %b required 1", txd_w[0]);
      end
      if (cnt_w[0] !== 3'd0) begin
         errors++; $display("FAIL midrst_cnt got %0d required 0", cnt_w[0]);
      end
      if (busy_w[0] !== 1'b0) begin
         errors++; $display("FAIL midrst_busy got %b required 0", busy_w[0]);
      end
      if (rdy_w[0] !== 1'b0) begin
         errors++; $display("FAIL midrst_ready_in_rst got %b required 0", rdy_w[0]);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (rdy_w[0] !== 1'b1) begin
         errors++; $display("FAIL midrst_ready_after got %b required 1", rdy_w[0]);
      end
      for (int n = 0; n < 100; n++) begin
         tick();
         checks += 2;
         if (txd_w[0] !== 1'b1) begin
            errors++; $display("FAIL midrst_quiet_txd n=%0d got %b required 1", n, txd_w[0]);
         end
         if (busy_w[0] !== 1'b0) begin
            errors++; $display("FAIL midrst_quiet_busy n=%0d got %b required 0", n, busy_w[0]);
         end
      end
   endtask

   // Random traffic on all instances with occasional reset pulses.
   task automatic test_random();
      for (int n = 0; n < 4000; n++) begin
         for (int k = 0; k < NI; k++) begin
            if (!vld[k] || macc[k]) begin
               vld[k] = ($urandom_range(0, 2) == 0);
               dat[k] = 8'($urandom);
            end
         end
         rst = ($urandom_range(0, 999) == 0);
         tick();
         for (int k = 0; k < NI; k++) begin
            checks += 4;
            if (txd_w[k] !== exp_txd(k)) begin
               errors++;
               $display("FAIL rand_txd k=%0d pos=%0d got %b required %b", k, mpos[k],
                        txd_w[k], exp_txd(k));
            end
            if (busy_w[k] !== exp_busy(k)) begin
               errors++; $display("FAIL rand_busy k=%0d got %b required %b", k, busy_w[k],
                                  exp_busy(k));
            end
            if (rdy_w[k] !== exp_ready(k)) begin
               errors++; $display("FAIL rand_ready k=%0d got %b required %b", k, rdy_w[k],
                                  exp_ready(k));
            end
            if (cnt_w[k] !== 3'(mcnt[k])) begin
               errors++; $display("FAIL rand_cnt k=%0d got %0d required %0d", k, cnt_w[k],
                                  mcnt[k]);
            end
         end
      end
      rst = 1'b0;
      for (int k = 0; k < NI; k++) vld[k] = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      for (int k = 0; k < NI; k++) begin
         vld[k]   = 1'b0;
         dat[k]   = 8'h00;
         mhead[k] = 0;
         mcnt[k]  = 0;
         mpos[k]  = -1;
         mcur[k]  = 8'h00;
         macc[k]  = 1'b0;
      end
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_reset_mid_frame();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog got timeout required completion");
      $fatal(1, "watchdog expired");
   end
endmodule
